// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path types and constants.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DONE,
    DISCARD
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned ETH_MAX_BYTES = 1522;

endpackage

// File: rtl/rmii_sample_strobe.sv
// Symbol sample strobe: every cycle at 100 Mb/s, mid-symbol of a DIV_10M divider at 10 Mb/s.
module rmii_sample_strobe #(
  parameter int unsigned DIV_10M = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic speed_10,
  input  logic restart,
  output logic strobe
);

  localparam int unsigned CW = (DIV_10M > 1) ? $clog2(DIV_10M) : 1;

  logic [CW-1:0] div_q, div_d, div_cur;

  always_comb begin
    // The restart cycle counts as divider phase 0.
    div_cur = restart ? '0 : div_q;
    strobe  = 1'b1;
    div_d   = '0;
    if (speed_10) begin
      strobe = (div_cur == CW'(DIV_10M / 2));
      div_d  = (div_cur == CW'(DIV_10M - 1)) ? '0 : div_cur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII/MII receive deframer: strips preamble/SFD, assembles bytes LSB-symbol first and
// emits a sof/eof/err framed byte stream with a one-byte holdback.
module rmii_rx_deframer
  import eth_pkg::*;
#(
  parameter int unsigned IN_W      = 2,
  parameter int unsigned DIV_10M   = 10,
  parameter int unsigned MAX_BYTES = ETH_MAX_BYTES
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            speed_10,
  input  logic            crs_dv,
  input  logic [IN_W-1:0] rxd,
  input  logic            rx_er,
  output logic [7:0]      out_data,
  output logic            out_valid,
  output logic            out_sof,
  output logic            out_eof,
  output logic            out_err,
  output logic [10:0]     frame_len
);

  localparam int unsigned SYMS  = 8 / IN_W;
  localparam int unsigned IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYMS - 1);
  localparam logic [IN_W-1:0]  PRE_SYM  = PREAMBLE_BYTE[IN_W-1:0];
  localparam logic [IN_W-1:0]  SFD_SYM  = SFD_BYTE[7 -: IN_W];
  localparam logic [10:0]      MAX_CNT  = 11'(MAX_BYTES);
  localparam logic [10:0]      CNT_SAT  = 11'(MAX_BYTES + 1);

  rx_state_t       state_q, state_d;
  logic            speed_q, speed_d, speed_sel;
  logic            crs_prev_q, seen_low_q, seen_low_d, low_q, low_d;
  logic [IN_W-1:0] dly_sym_q, dly_sym_d;
  logic            dly_vld_q, dly_vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]      shift_q, shift_d, hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d, first_q, first_d, err_q, err_d;
  logic [10:0]     cnt_q, cnt_d, len_q, len_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, oerr_q, oerr_d;
  logic            restart, strobe, end_det;

  assign speed_sel = (state_q == IDLE) ? speed_10 : speed_q;
  assign restart   = (state_q == IDLE) && crs_dv && !crs_prev_q;
  assign end_det   = strobe && !crs_dv && low_q;

  rmii_sample_strobe #(
    .DIV_10M(DIV_10M)
  ) u_strobe (
    .clk     (clk),
    .resetn  (resetn),
    .speed_10(speed_sel),
    .restart (restart),
    .strobe  (strobe)
  );

  always_comb begin
    state_d    = state_q;
    speed_d    = (state_q == IDLE) ? speed_10 : speed_q;
    seen_low_d = seen_low_q | !crs_dv;
    low_d      = strobe ? !crs_dv : low_q;
    dly_sym_d  = dly_sym_q;
    dly_vld_d  = dly_vld_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    first_d    = first_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    oerr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Carrier already up when leaving reset: never join a frame mid-stream.
        if (crs_dv && !seen_low_q) begin
          state_d = DISCARD;
        end else if (strobe && crs_dv) begin
          state_d = (rxd == PRE_SYM) ? PREAMBLE : DISCARD;
        end
      end
      PREAMBLE: begin
        if (strobe) begin
          if (end_det) begin
            state_d = IDLE;
          end else if (rxd == SFD_SYM) begin
            state_d    = DATA;
            idx_d      = '0;
            dly_vld_d  = 1'b0;
            hold_vld_d = 1'b0;
            first_d    = 1'b1;
            err_d      = 1'b0;
            cnt_d      = '0;
          end else if (rxd != PRE_SYM) begin
            state_d = crs_dv ? DISCARD : IDLE;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          if (end_det) begin
            // The delayed symbol is the first low sample of the end marker; drop it.
            state_d    = DONE;
            hold_vld_d = 1'b0;
            if (hold_vld_q) begin
              valid_d = 1'b1;
              data_d  = hold_q;
              sof_d   = first_q;
              eof_d   = 1'b1;
              oerr_d  = err_q | (idx_q != '0);
              len_d   = cnt_q;
            end
          end else begin
            // Symbols commit one sample late so a lone low CRS_DV sample can still be data.
            err_d     = err_q | rx_er;
            dly_sym_d = rxd;
            dly_vld_d = 1'b1;
            if (dly_vld_q) begin
              for (int unsigned s = 0; s < SYMS; s++) begin
                if (idx_q == IDX_W'(s)) shift_d[s*IN_W +: IN_W] = dly_sym_q;
              end
              if (idx_q == IDX_LAST) begin
                idx_d = '0;
                if (cnt_q < MAX_CNT) begin
                  if (hold_vld_q) begin
                    valid_d = 1'b1;
                    data_d  = hold_q;
                    sof_d   = first_q;
                    first_d = 1'b0;
                  end
                  hold_d     = shift_d;
                  hold_vld_d = 1'b1;
                  cnt_d      = cnt_q + 11'd1;
                end else begin
                  cnt_d = CNT_SAT;
                  err_d = 1'b1;
                end
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DISCARD: begin
        if (end_det) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      speed_q    <= 1'b0;
      crs_prev_q <= 1'b0;
      seen_low_q <= 1'b0;
      low_q      <= 1'b0;
      dly_sym_q  <= '0;
      dly_vld_q  <= 1'b0;
      idx_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      crs_prev_q <= crs_dv;
      seen_low_q <= seen_low_d;
      low_q      <= low_d;
      dly_sym_q  <= dly_sym_d;
      dly_vld_q  <= dly_vld_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      first_q    <= first_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      oerr_q     <= oerr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign out_err   = oerr_q;
  assign frame_len = len_q;

endmodule
